// File: rtl/rand_delay_pkg.sv
// rand_delay_pkg: shared FSM state type and interval math for rand_delay_timer
package rand_delay_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, FIRE} state_t;
  function automatic logic [31:0] calc_delay(input logic [31:0] rnd, input int unsigned shift, input int unsigned min_d);
    return (rnd << shift) + min_d;
  endfunction
endpackage

// File: rtl/rand_delay_counter.sv
// rand_delay_counter: loadable down-counter with clear, load, decrement and zero flag
//   clk, reset_n (async, active-low); clr > load > dec priority; load_val; count; zero = (count == 0)
module rand_delay_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else count <= clr ? '0 : load ? load_val : dec ? count - W'(1) : count;
  assign zero = count == '0;
endmodule

// File: rtl/rand_delay_timer.sv
// rand_delay_timer: turns a sampled LFSR word into a countdown interval and raises expired
//   clk, reset_n (async, active-low); rand_value: LFSR word; start/abort/ack: control;
//   busy = not idle; expired = in FIRE; remaining = current countdown value.
//   Define RAND_DELAY_AUTORELOAD_EN to make ack in FIRE resample and restart immediately.
module rand_delay_timer
  import rand_delay_pkg::*;
#(
  parameter int RAND_W      = 5,
  parameter int SCALE_SHIFT = 2,
  parameter int MIN_DELAY   = 3,
  localparam int CNT_W      = RAND_W + SCALE_SHIFT + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RAND_W-1:0] rand_value,
  input  logic              start,
  input  logic              abort,
  input  logic              ack,
  output logic              busy,
  output logic              expired,
  output logic [CNT_W-1:0]  remaining
);
`ifdef RAND_DELAY_AUTORELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif
  state_t state, nxt;
  logic [CNT_W-1:0] d;
  logic load, dec, zero;
  assign d = CNT_W'(calc_delay(32'(rand_value), SCALE_SHIFT, MIN_DELAY));
  // loading D-1 and firing on the edge that sees zero makes expired rise exactly D edges after start
  assign load = !abort && ((state == IDLE && start) || (AUTO_RELOAD && state == FIRE && ack));
  assign dec  = state == COUNT && !zero;
  always_comb
    nxt = abort ? IDLE :
          state == IDLE  ? (start ? COUNT : IDLE) :
          state == COUNT ? (zero ? FIRE : COUNT) :
          ack ? (AUTO_RELOAD ? COUNT : IDLE) : FIRE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  rand_delay_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .reset_n(reset_n), .clr(abort), .load(load), .dec(dec),
    .load_val(d - CNT_W'(1)), .count(remaining), .zero(zero)
  );
  assign busy    = state != IDLE;
  assign expired = state == FIRE;
endmodule

// File: tb/tb_rand_delay_timer.sv
module tb_rand_delay_timer;
  localparam int RAND_W = 5, SCALE_SHIFT = 2, MIN_DELAY = 3, CNT_W = 8;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, ack = 0;
  logic [RAND_W-1:0] rand_value = '0;
  logic busy, expired;
  logic [CNT_W-1:0] remaining;
  int n_chk = 0, n_fail = 0;
  int exp_q[$];

  rand_delay_timer #(.RAND_W(RAND_W), .SCALE_SHIFT(SCALE_SHIFT), .MIN_DELAY(MIN_DELAY)) dut (
    .clk(clk), .reset_n(reset_n), .rand_value(rand_value), .start(start), .abort(abort),
    .ack(ack), .busy(busy), .expired(expired), .remaining(remaining)
  );

  always #5 clk = ~clk;

  function automatic int model_d(input int rv);
    return MIN_DELAY + (rv << SCALE_SHIFT);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // start an interval, push its expected length, check the load and scramble rand_value afterwards
  task automatic start_interval(input int rv);
    int d;
    d = model_d(rv);
    rand_value = RAND_W'(rv);
    start = 1;
    exp_q.push_back(d);
    tick;
    start = 0;
    rand_value = ~RAND_W'(rv);
    n_chk++;
    if (remaining !== CNT_W'(d - 1) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load rv=%0d: remaining=%0d busy=%b, want remaining=%0d busy=1", rv, remaining, busy, d - 1);
    end
  endtask

  // count edges until expired; elapsed = edges already seen after the start edge
  task automatic wait_expire(input int elapsed);
    int cnt, d;
    cnt = elapsed;
    while (!expired && cnt < 300) begin
      tick;
      cnt++;
    end
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: expired with no expected interval queued");
    end else begin
      d = exp_q.pop_front();
      if (cnt !== d || expired !== 1'b1 || remaining !== '0) begin
        n_fail++;
        $display("FAIL interval: expired=%b after %0d edges remaining=%0d, want expired=1 after %0d edges remaining=0", expired, cnt, remaining, d);
      end
    end
  endtask

  task automatic do_ack;
    ack = 1;
    tick;
    ack = 0;
    n_chk++;
    if (expired !== 1'b0) begin
      n_fail++;
      $display("FAIL ack: expired=%b, want 0", expired);
    end
  endtask

  task automatic test_reset;
    n_chk++;
    if (busy !== 1'b0 || expired !== 1'b0 || remaining !== '0) begin
      n_fail++;
      $display("FAIL reset_init: busy=%b expired=%b remaining=%0d, want 0 0 0", busy, expired, remaining);
    end
    tick;
    reset_n = 1;
    tick;
    rand_value = 5;
    start = 1;
    tick;
    start = 0;
    repeat (4) tick;
    #2 reset_n = 0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || expired !== 1'b0 || remaining !== '0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b expired=%b remaining=%0d, want 0 0 0", busy, expired, remaining);
    end
    tick;
    reset_n = 1;
    tick;
    n_chk++;
    if (busy !== 1'b0 || remaining !== '0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b remaining=%0d, want 0 0", busy, remaining);
    end
  endtask

  task automatic test_basic;
    start_interval(5);
    wait_expire(0);
    repeat (3) tick;
    n_chk++;
    if (expired !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold: expired=%b busy=%b, want 1 1", expired, busy);
    end
    do_ack;
  endtask

  task automatic test_bounds;
    tick;
    start_interval(0);
    wait_expire(0);
    do_ack;
    tick;
    start_interval(31);
    wait_expire(0);
    do_ack;
  endtask

  task automatic test_abort;
    tick;
    start_interval(5);
    repeat (10) tick;
    abort = 1;
    tick;
    abort = 0;
    void'(exp_q.pop_front());
    n_chk++;
    if (busy !== 1'b0 || remaining !== '0) begin
      n_fail++;
      $display("FAIL abort_count: busy=%b remaining=%0d, want 0 0", busy, remaining);
    end
    start_interval(0);
    wait_expire(0);
    abort = 1;
    ack = 1;
    tick;
    abort = 0;
    ack = 0;
    n_chk++;
    if (busy !== 1'b0 || expired !== 1'b0 || remaining !== '0) begin
      n_fail++;
      $display("FAIL abort_fire: busy=%b expired=%b remaining=%0d, want 0 0 0", busy, expired, remaining);
    end
  endtask

  task automatic test_ignored;
    tick;
    start_interval(5);
    repeat (3) tick;
    rand_value = 31;
    start = 1;
    tick;
    start = 0;
    n_chk++;
    if (remaining !== CNT_W'(18)) begin
      n_fail++;
      $display("FAIL start_in_count: remaining=%0d, want 18", remaining);
    end
    ack = 1;
    tick;
    ack = 0;
    n_chk++;
    if (remaining !== CNT_W'(17) || busy !== 1'b1 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_in_count: remaining=%0d busy=%b expired=%b, want 17 1 0", remaining, busy, expired);
    end
    wait_expire(5);
    rand_value = 4;
    start = 1;
    ack = 1;
    tick;
    start = 0;
    ack = 0;
`ifdef RAND_DELAY_AUTORELOAD_EN
    n_chk++;
    if (busy !== 1'b1 || expired !== 1'b0 || remaining !== CNT_W'(model_d(4) - 1)) begin
      n_fail++;
      $display("FAIL start_ack_fire: busy=%b expired=%b remaining=%0d, want 1 0 %0d", busy, expired, remaining, model_d(4) - 1);
    end
    abort = 1;
    tick;
    abort = 0;
`else
    n_chk++;
    if (busy !== 1'b0 || expired !== 1'b0 || remaining !== '0) begin
      n_fail++;
      $display("FAIL start_ack_fire: busy=%b expired=%b remaining=%0d, want 0 0 0", busy, expired, remaining);
    end
`endif
  endtask

`ifdef RAND_DELAY_AUTORELOAD_EN
  task automatic test_autoreload;
    tick;
    start_interval(1);
    wait_expire(0);
    rand_value = 2;
    ack = 1;
    exp_q.push_back(model_d(2));
    tick;
    ack = 0;
    rand_value = 31;
    n_chk++;
    if (expired !== 1'b0 || busy !== 1'b1 || remaining !== CNT_W'(10)) begin
      n_fail++;
      $display("FAIL autoreload: expired=%b busy=%b remaining=%0d, want 0 1 10", expired, busy, remaining);
    end
    wait_expire(0);
    abort = 1;
    tick;
    abort = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_bounds;
    test_abort;
    test_ignored;
`ifdef RAND_DELAY_AUTORELOAD_EN
    test_autoreload;
`endif
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
